pulse_event_queue: RTL and testbench

- Single-clock front end that feeds a two-clock pulse synchronizer on its source side.
- Accumulates bursts of event notifications into a saturating pending counter. Issues exactly one single-cycle pulse per pending event to the synchronizer, and only when the synchronizer reports not-busy.
- Events arriving while a transfer is in flight are never lost; they are dropped only on saturation, which is flagged.
- Sits in the MAC-core clock domain, ahead of the stats/interrupt crossing.

---
 rtl/pulse_event_queue.sv | 133 +++++++++++++
 tb/tb_pulse_event_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_queue.sv
// Event accumulator ahead of a two-clock pulse synchronizer: one pulse per pending event.
// Optional saturating discard counter enabled by PULSE_EVENT_QUEUE_DROP_CNT_EN.
module pulse_event_queue #(
  parameter int CNT_WIDTH   = 8,
  parameter int EVT_WIDTH   = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 evt_valid,
  input  logic [EVT_WIDTH-1:0] evt_num,
  input  logic                 sync_busy,
  output logic                 sync_pulse,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 pending_full,
  output logic                 overflow,
  output logic                 ack_err,
  input  logic                 clr_err,
  output logic [15:0]          drop_cnt
);

  localparam int SUM_W = CNT_WIDTH + EVT_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] MAX_S =
    $signed({{(EVT_WIDTH+1){1'b0}}, {CNT_WIDTH{1'b1}}});

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_IDLE} state_t;

  state_t                  state;
  logic [7:0]              tmo;
  logic                    ack;
  logic                    timeout_hit;
  logic [EVT_WIDTH-1:0]    add;
  logic signed [SUM_W-1:0] sum;
  logic                    sat_hit;
  logic [CNT_WIDTH-1:0]    next_pending;

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic signed [SUM_W-1:0] s);
    if (s > MAX_S) return {CNT_WIDTH{1'b1}};
    return s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    ack          = (state == WAIT_ACK) && sync_busy;
    timeout_hit  = (state == WAIT_ACK) && !sync_busy && (tmo == 8'd1);
    add          = evt_valid ? evt_num : '0;
    // Wide signed sum so add, ack and the saturation check never wrap.
    sum          = $signed({{(EVT_WIDTH+1){1'b0}}, pending})
                 + $signed({{(CNT_WIDTH+1){1'b0}}, add})
                 - $signed({{(SUM_W-1){1'b0}}, ack});
    sat_hit      = (sum > MAX_S);
    next_pending = sat_cnt(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync_pulse <= 1'b0;
      tmo        <= '0;
      ack_err    <= 1'b0;
    end else begin
      ack_err <= timeout_hit | (ack_err & ~clr_err);
      case (state)
        IDLE: begin
          sync_pulse <= 1'b0;
          if (pending != '0 && !sync_busy) begin
            state      <= ISSUE;
            sync_pulse <= 1'b1;
          end
        end
        ISSUE: begin
          sync_pulse <= 1'b0;
          tmo        <= 8'(ACK_TIMEOUT);
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          sync_pulse <= 1'b0;
          if (sync_busy) begin
            state <= WAIT_IDLE;
          end else begin
            // Timeout leaves pending untouched so IDLE reissues the same event.
            tmo <= tmo - 8'd1;
            if (tmo == 8'd1) state <= IDLE;
          end
        end
        WAIT_IDLE: begin
          sync_pulse <= 1'b0;
          if (!sync_busy) state <= IDLE;
        end
        default: begin
          sync_pulse <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      pending      <= next_pending;
      pending_full <= (next_pending == {CNT_WIDTH{1'b1}});
      overflow     <= sat_hit | (overflow & ~clr_err);
    end
  end

`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
  logic signed [SUM_W-1:0] excess;
  logic [15:0]             excess16;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[16] ? 16'hFFFF : t[15:0];
  endfunction

  always_comb begin
    excess   = sum - MAX_S;
    excess16 = sat_hit ? 16'(unsigned'(excess)) : 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       drop_cnt <= '0;
    else if (clr_err) drop_cnt <= excess16;
    else if (sat_hit) drop_cnt <= sat_add16(drop_cnt, excess16);
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_event_queue.sv
// Bench for pulse_event_queue: directed scenarios plus randomized traffic against an event-count model.
module tb_pulse_event_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid = 1'b0;
  logic [1:0]  evt_num = '0;
  logic        sync_busy = 1'b0;
  logic        sync_pulse;
  logic [7:0]  pending;
  logic        pending_full;
  logic        overflow;
  logic        ack_err;
  logic        clr_err = 1'b0;
  logic [15:0] drop_cnt;

`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  pulse_event_queue #(.CNT_WIDTH(8), .EVT_WIDTH(2), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_num(evt_num),
    .sync_busy(sync_busy), .sync_pulse(sync_pulse), .pending(pending),
    .pending_full(pending_full), .overflow(overflow), .ack_err(ack_err),
    .clr_err(clr_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: event counts and a synchronizer that answers each pulse.
  int m_pend, m_drop;
  bit m_ovf;
  bit auto_mode, rand_busy;
  int busy_len, last_b, cyc, b_start, b_end, last_pulse, pulse_cnt, gap_err;
  bit busy_prev, pulse_prev;

  task automatic do_reset(input bit busy);
    rst_n = 1'b0; evt_valid = 1'b0; evt_num = '0; clr_err = 1'b0; sync_busy = busy;
    auto_mode = 0; rand_busy = 0; busy_len = 6; last_b = 6;
    m_pend = 0; m_drop = 0; m_ovf = 0;
    cyc = 0; b_start = -10; b_end = -10; last_pulse = -1; pulse_cnt = 0; gap_err = 0;
    busy_prev = 0; pulse_prev = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cycle(input bit v, input int n, input bit c);
    int add, sum, disc;
    bit ack;
    evt_valid = v; evt_num = 2'(n); clr_err = c;
    ack  = auto_mode && sync_busy && !busy_prev;
    add  = v ? n : 0;
    sum  = m_pend + add - (ack ? 1 : 0);
    disc = (sum > 255) ? sum - 255 : 0;
    m_pend = (sum > 255) ? 255 : sum;
    m_ovf  = (disc > 0) || (m_ovf && !c);
    m_drop = c ? disc : ((m_drop + disc > 65535) ? 65535 : m_drop + disc);
    busy_prev  = sync_busy;
    pulse_prev = sync_pulse;
    @(posedge clk); #1;
    cyc++;
    if (auto_mode) begin
      if (sync_pulse) begin
        pulse_cnt++;
        if (last_pulse >= 0 && cyc - last_pulse < 4 + last_b) gap_err++;
        last_pulse = cyc;
        if (rand_busy) busy_len = $urandom_range(1, 6);
        last_b  = busy_len;
        b_start = cyc + 2;
        b_end   = cyc + 1 + busy_len;
      end
      sync_busy = (cyc >= b_start && cyc <= b_end);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++; if (pending !== 8'd0) begin miscompares++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    vectors++; if ({sync_pulse, overflow, ack_err, pending_full} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got=%b exp=0000", {sync_pulse, overflow, ack_err, pending_full}); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_idle_pulse got=%b exp=0", sync_pulse); end
  endtask

  task automatic test_burst();
    do_reset(1'b0);
    auto_mode = 1;
    cycle(1, 3, 0);
    vectors++; if (pending !== 8'd3) begin miscompares++; $display("FAIL burst_load got=%0d exp=3", pending); end
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0);
      vectors++; if (pending !== 8'(m_pend)) begin
        miscompares++; $display("FAIL burst_pending cyc=%0d got=%0d exp=%0d", cyc, pending, m_pend); end
      vectors++; if (sync_pulse && (sync_busy || pulse_prev)) begin
        miscompares++; $display("FAIL burst_pulse_rule cyc=%0d busy=%b prev=%b exp=no pulse", cyc, sync_busy, pulse_prev); end
    end
    vectors++; if (pulse_cnt != 3) begin miscompares++; $display("FAIL burst_pulse_count got=%0d exp=3", pulse_cnt); end
    vectors++; if (gap_err != 0) begin miscompares++; $display("FAIL burst_spacing got=%0d short gaps exp=0", gap_err); end
    vectors++; if (pending !== 8'd0) begin miscompares++; $display("FAIL burst_drain got=%0d exp=0", pending); end
  endtask

  task automatic test_add_and_ack();
    do_reset(1'b1);
    cycle(1, 3, 0);
    cycle(1, 2, 0);
    vectors++; if (pending !== 8'd5) begin miscompares++; $display("FAIL addack_preload got=%0d exp=5", pending); end
    sync_busy = 1'b0;
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b1) begin miscompares++; $display("FAIL addack_issue got=%b exp=1", sync_pulse); end
    cycle(0, 0, 0);
    sync_busy = 1'b1;
    cycle(1, 2, 0);
    vectors++; if (pending !== 8'd6) begin miscompares++; $display("FAIL addack_pending got=%0d exp=6", pending); end
  endtask

  task automatic test_saturation();
    do_reset(1'b1);
    for (int i = 0; i < 84; i++) cycle(1, 3, 0);
    cycle(1, 2, 0);
    vectors++; if ({pending, pending_full, overflow} !== {8'd254, 2'b00}) begin
      miscompares++; $display("FAIL sat_preload got=%0d full=%b ovf=%b exp=254 0 0", pending, pending_full, overflow); end
    cycle(1, 3, 0);
    vectors++; if ({pending, pending_full, overflow} !== {8'd255, 2'b11}) begin
      miscompares++; $display("FAIL sat_hit got=%0d full=%b ovf=%b exp=255 1 1", pending, pending_full, overflow); end
    vectors++; if (drop_cnt !== (DROP_EN ? 16'd2 : 16'd0)) begin
      miscompares++; $display("FAIL sat_drop got=%0d exp=%0d", drop_cnt, DROP_EN ? 2 : 0); end
    cycle(0, 0, 1);
    vectors++; if ({pending, overflow, drop_cnt} !== {8'd255, 1'b0, 16'd0}) begin
      miscompares++; $display("FAIL sat_clear got=%0d ovf=%b drop=%0d exp=255 0 0", pending, overflow, drop_cnt); end
    cycle(1, 1, 1);
    vectors++; if ({overflow, drop_cnt} !== {1'b1, (DROP_EN ? 16'd1 : 16'd0)}) begin
      miscompares++; $display("FAIL sat_clear_vs_set ovf=%b drop=%0d exp=1 %0d", overflow, drop_cnt, DROP_EN ? 1 : 0); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b1) begin miscompares++; $display("FAIL tmo_issue got=%b exp=1", sync_pulse); end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0);
      vectors++; if ({sync_pulse, ack_err} !== 2'b00) begin
        miscompares++; $display("FAIL tmo_wait step=%0d pulse=%b err=%b exp=0 0", i, sync_pulse, ack_err); end
    end
    cycle(0, 0, 0);
    vectors++; if ({ack_err, pending} !== {1'b1, 8'd1}) begin
      miscompares++; $display("FAIL tmo_err err=%b pending=%0d exp=1 1", ack_err, pending); end
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b1) begin miscompares++; $display("FAIL tmo_reissue got=%b exp=1", sync_pulse); end
    cycle(0, 0, 1);
    vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL tmo_clear got=%b exp=0", ack_err); end
  endtask

  task automatic test_stale_busy();
    do_reset(1'b1);
    cycle(1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      vectors++; if ({sync_pulse, pending} !== {1'b0, 8'd2}) begin
        miscompares++; $display("FAIL stale_hold pulse=%b pending=%0d exp=0 2", sync_pulse, pending); end
    end
    sync_busy = 1'b0;
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b1) begin miscompares++; $display("FAIL stale_release got=%b exp=1", sync_pulse); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    cycle(1, 3, 0);
    cycle(1, 1, 0);
    sync_busy = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    vectors++; if (pending !== 8'd4) begin miscompares++; $display("FAIL arst_preload got=%0d exp=4", pending); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({pending, sync_pulse, overflow, ack_err} !== 11'd0) begin
      miscompares++; $display("FAIL arst_immediate pending=%0d pulse=%b exp=0 0", pending, sync_pulse); end
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1, 1, 0);
    vectors++; if ({pending, sync_pulse} !== {8'd1, 1'b0}) begin
      miscompares++; $display("FAIL arst_after pending=%0d pulse=%b exp=1 0", pending, sync_pulse); end
    cycle(0, 0, 0);
    vectors++; if (sync_pulse !== 1'b1) begin miscompares++; $display("FAIL arst_idle_issue got=%b exp=1", sync_pulse); end
  endtask

  task automatic test_random();
    bit v, c;
    int n;
    do_reset(1'b0);
    auto_mode = 1; rand_busy = 1;
    for (int i = 0; i < 500; i++) begin
      v = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      n = $urandom_range(0, 3);
      c = ($urandom_range(0, 19) == 0);
      cycle(v, n, c);
      vectors++; if (pending !== 8'(m_pend)) begin
        miscompares++; $display("FAIL rand_pending cyc=%0d got=%0d exp=%0d", cyc, pending, m_pend); end
      vectors++; if (pending_full !== (m_pend == 255)) begin
        miscompares++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, pending_full, m_pend == 255); end
      vectors++; if (overflow !== m_ovf) begin
        miscompares++; $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); end
      vectors++; if (drop_cnt !== (DROP_EN ? 16'(m_drop) : 16'd0)) begin
        miscompares++; $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", cyc, drop_cnt, DROP_EN ? m_drop : 0); end
      vectors++; if (ack_err !== 1'b0) begin
        miscompares++; $display("FAIL rand_ack_err cyc=%0d got=%b exp=0", cyc, ack_err); end
      vectors++; if (sync_pulse && (sync_busy || pulse_prev)) begin
        miscompares++; $display("FAIL rand_pulse_rule cyc=%0d busy=%b prev=%b exp=no pulse", cyc, sync_busy, pulse_prev); end
    end
    vectors++; if (gap_err != 0) begin miscompares++; $display("FAIL rand_spacing got=%0d short gaps exp=0", gap_err); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_add_and_ack();
    test_saturation();
    test_timeout();
    test_stale_busy();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
